fmap_stream_source: RTL
=======================

Name: fmap_stream_source

Overview:
- Transmit end of the per-layer pixel stream.
- Reads one layer's input feature map from a synchronous-read on-chip buffer in raster order (column fastest, then row, then channel).
- Drives the `valid_in` pixel stream consumed by the layer control chain (line padding → 2D pipeline → bias → max-pooling), one pixel per cycle unless paused.
- Reports frame position, a last-pixel flag and completion to the layer sequencer.

Parameters:
- WIDTH, 5, feature-map width = height in pixels
- CHANNELS, 1, input channels streamed back-to-back per start
- DATA_W, 16, pixel width in bits
- ADDR_W, 16, buffer address width
- BASE_ADDR, 0, buffer address of channel 0, row 0, col 0

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  single-cycle request to stream the whole map; sampled only in IDLE
- pause  input  1  while high, no new buffer read is issued
- mem_en  output  1  buffer read enable
- mem_addr  output  ADDR_W  buffer read address
- mem_rdata  input  DATA_W  buffer read data, valid exactly 1 cycle after mem_en
- pixel_out  output  DATA_W  streamed pixel
- valid_out  output  1  pixel_out valid; drives the chain's valid_in
- counter_col  output  32  column of current pixel_out
- counter_row  output  32  row of current pixel_out
- channel_idx  output  32  channel of current pixel_out
- last_pixel  output  1  high with the final pixel of the final channel
- busy  output  1  high from accepted start through the done cycle
- done  output  1  one-cycle pulse after the final valid_out

Behaviour:
- Reset values (rst high at a clock edge): all outputs 0; state IDLE; issue counters 0; in-flight pipeline flushed.
- Reset mid-stream aborts the stream with no further valid_out and no done pulse.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE→ISSUE: on start. Issue counters col, row and ch are cleared.
  - ISSUE: in each cycle with pause low, mem_en=1 and mem_addr = BASE_ADDR + ch·WIDTH² + row·WIDTH + col. Counters then advance: col wraps WIDTH-1→0 and increments row; row wraps WIDTH-1→0 and increments ch.
  - ISSUE with pause high: mem_en=0, counters hold.
  - ISSUE→DRAIN: after the issue of (WIDTH-1, WIDTH-1, CHANNELS-1).
  - DRAIN→DONE: when the in-flight pipeline is empty, i.e. the cycle after the last valid_out.
  - DONE: done=1 for one cycle, then →IDLE.
- mem_addr is computed in ADDR_W bits and truncates on overflow. The address is held while mem_en=0.
- Latency, two registered stages:
  - Stage 1 captures mem_en and the issue coordinates.
  - Stage 2 registers pixel_out ← mem_rdata, together with valid_out, counter_col, counter_row, channel_idx and last_pixel.
  - valid_out rises exactly 2 cycles after its mem_en.
- pause affects issue only. Pixels already in flight still emerge, so the valid_out pattern is the mem_en pattern delayed by 2. There is no backpressure from the chain.
- While valid_out=0, pixel_out and the coordinate outputs hold their last values.
- busy=1 from the cycle after the accepted start through the DONE cycle inclusive.
- start while busy is ignored, with no restart and no counter disturbance.
- start in the cycle after DONE (state IDLE) is accepted.
- Unpaused stream: WIDTH²·CHANNELS consecutive valid_out cycles. The first mem_en is in the cycle after start, so the first valid_out is 3 cycles after start.
- Simultaneous pause and the final issue slot: the final issue waits until pause is low. DRAIN is entered only after the final read is issued.

Test Plan:
- Basic stream (WIDTH=5, CHANNELS=1, BASE_ADDR=0; buffer[a]=a):
  - start at cycle 0 → mem_en cycles 1–25 with addresses 0..24.
  - valid_out cycles 3–27 with pixel_out 0..24; col/row sweep (0,0)..(4,4).
  - last_pixel at cycle 27 only; done at cycle 28; busy cycles 1–28.
- Pause: as the basic stream, with pause high for cycles 6–8 →
  - no mem_en in cycles 6–8; valid_out low in cycles 8–10.
  - pixel sequence still 0..24 with no duplicates or skips; done at cycle 31.
- Multi-channel (WIDTH=3, CHANNELS=2, BASE_ADDR=100) →
  - addresses 100..117.
  - channel_idx 0 for the first 9 pixels, then 1.
  - last_pixel on the 18th pixel only.
- Ignored start: start re-pulsed at cycle 10 of the basic stream → output identical to the basic stream.
- Back-to-back start: start pulsed in the cycle after done → a second identical stream begins.
- Reset mid-stream: rst at cycle 12 →
  - from the next cycle, all outputs 0 and no further valid_out; done never pulses.
  - a subsequent start streams from address 0.

Source files
------------

// File: rtl/fmap_stream_source.sv
// rtl/fmap_stream_source.sv - streams one layer's feature map from a sync-read buffer in raster order
// Two-stage read pipeline: stage 1 tracks the issued read, stage 2 captures buffer data.
module fmap_stream_source #(
  parameter int WIDTH     = 5,
  parameter int CHANNELS  = 1,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pixel_out,
  output logic              valid_out,
  output logic [31:0]       counter_col,
  output logic [31:0]       counter_row,
  output logic [31:0]       channel_idx,
  output logic              last_pixel,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [31:0] W_LAST = 32'(WIDTH - 1);
  localparam logic [31:0] C_LAST = 32'(CHANNELS - 1);
  localparam logic [31:0] PLANE  = 32'(WIDTH * WIDTH);

  state_t state_q, state_d;
  logic [31:0] col_q, col_d;
  logic [31:0] row_q, row_d;
  logic [31:0] ch_q, ch_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_calc;
  logic issue;
  logic is_last;

  logic        s1_valid_q;
  logic        s1_last_q;
  logic [31:0] s1_col_q;
  logic [31:0] s1_row_q;
  logic [31:0] s1_ch_q;

  logic [DATA_W-1:0] pix_q;
  logic              vld_q;
  logic              last_q;
  logic [31:0]       col_out_q;
  logic [31:0]       row_out_q;
  logic [31:0]       ch_out_q;

  assign is_last   = (col_q == W_LAST) && (row_q == W_LAST) && (ch_q == C_LAST);
  assign addr_calc = ADDR_W'(BASE_ADDR) + ADDR_W'(ch_q * PLANE)
                   + ADDR_W'(row_q * 32'(WIDTH)) + ADDR_W'(col_q);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    ch_d    = ch_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          col_d   = '0;
          row_d   = '0;
          ch_d    = '0;
        end
      end
      ISSUE: begin
        if (!pause) begin
          issue = 1'b1;
          if (col_q == W_LAST) begin
            col_d = '0;
            if (row_q == W_LAST) begin
              row_d = '0;
              ch_d  = ch_q + 32'd1;
            end else begin
              row_d = row_q + 32'd1;
            end
          end else begin
            col_d = col_q + 32'd1;
          end
          if (is_last) begin
            state_d = DRAIN;
          end
        end
      end
      // Stage 1 empty means the final pixel is in stage 2 this cycle.
      DRAIN: begin
        if (!s1_valid_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      ch_q    <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      ch_q    <= ch_d;
      if (issue) begin
        addr_q <= addr_calc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_col_q   <= '0;
      s1_row_q   <= '0;
      s1_ch_q    <= '0;
    end else begin
      s1_valid_q <= issue;
      if (issue) begin
        s1_last_q <= is_last;
        s1_col_q  <= col_q;
        s1_row_q  <= row_q;
        s1_ch_q   <= ch_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_q     <= '0;
      vld_q     <= 1'b0;
      last_q    <= 1'b0;
      col_out_q <= '0;
      row_out_q <= '0;
      ch_out_q  <= '0;
    end else begin
      vld_q  <= s1_valid_q;
      last_q <= s1_valid_q && s1_last_q;
      if (s1_valid_q) begin
        pix_q     <= mem_rdata;
        col_out_q <= s1_col_q;
        row_out_q <= s1_row_q;
        ch_out_q  <= s1_ch_q;
      end
    end
  end

  assign mem_en      = issue;
  assign mem_addr    = issue ? addr_calc : addr_q;
  assign pixel_out   = pix_q;
  assign valid_out   = vld_q;
  assign counter_col = col_out_q;
  assign counter_row = row_out_q;
  assign channel_idx = ch_out_q;
  assign last_pixel  = last_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);

endmodule
